// File: rtl/mdu_pipe_unit.sv
// Multi-cycle multiply/divide unit that owns the HI/LO pair; sits beside the ALU in EX.
// Results are computed from latched operands and committed on the final busy cycle's edge.
module mdu_pipe_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam int CW = 6;
  localparam int W2 = 2 * WIDTH;

  logic [0:0]       state;
  logic [CW-1:0]    count;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [W2-1:0]    acc_q;

  logic             sgn, b_zero, ovf, res_we, finish;
  logic [W2-1:0]    ext_a, ext_b, prod, res, next_acc;
  logic [WIDTH-1:0] div_b, quo, rem, hi_w, lo_w;
  logic [CW-1:0]    load_cnt;

  // op[0] selects unsigned in every family; op[2] = accumulate, op[1] = subtract / divide.
  always_comb begin
    sgn    = ~op_q[0];
    ext_a  = sgn ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b  = sgn ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod   = ext_a * ext_b;
    b_zero = (b_q == '0);
    ovf    = sgn && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
    // Dividing the most negative value by 1 yields exactly the defined overflow result.
    div_b  = (b_zero || ovf) ? WIDTH'(1) : b_q;
    if (sgn) begin
      quo = $signed(a_q) / $signed(div_b);
      rem = $signed(a_q) % $signed(div_b);
    end else begin
      quo = a_q / div_b;
      rem = a_q % div_b;
    end
    res    = prod;
    res_we = 1'b1;
    if (op_q[2]) begin
      res = op_q[1] ? (acc_q - prod) : (acc_q + prod);
    end else if (op_q[1]) begin
      res    = {rem, quo};
      res_we = ~b_zero;
    end
  end

  always_comb begin
    load_cnt = (~op[2] & op[1]) ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
    hi_w     = hi_we ? wdata : hi;
    lo_w     = lo_we ? wdata : lo;
    finish   = (state == S_RUN) && (count == CW'(1)) && !cancel;
    next_acc = res_we ? res : {hi, lo};
  end

  assign busy = (state == S_RUN);
  assign done = finish;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          hi <= hi_w;
          lo <= lo_w;
          if (start) begin
            op_q  <= op;
            a_q   <= src_a;
            b_q   <= src_b;
            acc_q <= {hi_w, lo_w};
            count <= load_cnt;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (cancel) begin
            state <= S_IDLE;
            count <= '0;
          end else if (count == CW'(1)) begin
            if (res_we) {hi, lo} <= res;
            // A start in the done cycle chains directly, accumulating onto the fresh result.
            if (start) begin
              op_q  <= op;
              a_q   <= src_a;
              b_q   <= src_b;
              acc_q <= next_acc;
              count <= load_cnt;
            end else begin
              state <= S_IDLE;
              count <= '0;
            end
          end else begin
            count <= count - CW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/mdu_pipe_unit.md
Name: mdu_pipe_unit

Overview:
- Parametrised multi-cycle multiply/divide unit owning the HI/LO register pair.
- Sits in the EX stage beside the ALU. The hazard unit stalls on `busy`; MEM/WB read `hi`/`lo` for mfhi/mflo.
- Successor to the fixed 32-bit mult/div unit. Adds:
  - width and latency parameters;
  - multiply-accumulate and multiply-subtract;
  - a `done` strobe and a `cancel` input;
  - defined divide-by-zero and overflow results.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO.
- MUL_CYCLES, 5, busy cycles for multiply, madd and msub ops (legal range 1..31).
- DIV_CYCLES, 10, busy cycles for divide ops (legal range 1..63).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launch op; sampled only in IDLE.
- op  input  3  operation select:
  - 000 mult, 001 multu, 010 div, 011 divu;
  - 100 madd, 101 maddu, 110 msub, 111 msubu.
- src_a  input  WIDTH  rs operand (forwarded).
- src_b  input  WIDTH  rt operand (forwarded).
- hi_we  input  1  mthi write enable.
- lo_we  input  1  mtlo write enable.
- wdata  input  WIDTH  mthi/mtlo data.
- cancel  input  1  abort the in-flight op (exception flush).
- busy  output  1  op in progress.
- done  output  1  one-cycle pulse when HI/LO take a result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset: hi=0, lo=0, busy=0, done=0, state IDLE, counter 0. Reset has priority over every other input, including mid-operation; any in-flight result is discarded.
- States: IDLE, RUN.
- IDLE:
  - hi_we/lo_we load wdata into hi/lo at the clock edge.
  - start=1 latches op, src_a, src_b and the accumulator {hi,lo}, then moves to RUN. The counter is loaded with MUL_CYCLES (op 0x0/0x1/1xx) or DIV_CYCLES (op 01x).
  - start together with hi_we/lo_we in the same cycle: the write applies first. The latched accumulator uses the written value.
- RUN:
  - busy=1 from the cycle after start for exactly N cycles (N = MUL_CYCLES or DIV_CYCLES).
  - The counter decrements each cycle. On the edge where it reaches 0: hi/lo update, done=1 for one cycle, state returns to IDLE, busy drops in that same cycle.
  - Back-to-back: start is legal in the cycle done=1.
- In RUN, these are ignored: start, hi_we, lo_we, and changes on src_a/src_b/op. The hazard unit guarantees stall.
- cancel=1 in RUN: return to IDLE next edge, busy=0, done=0, hi/lo unchanged. cancel in IDLE has no effect.
- mult/multu: {hi,lo} = full 2*WIDTH product, signed or unsigned.
- madd/maddu: {hi,lo} = acc + product, modulo 2^(2*WIDTH).
- msub/msubu: {hi,lo} = acc - product, modulo 2^(2*WIDTH).
- div/divu: lo = quotient, hi = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero: op runs the full DIV_CYCLES and done pulses, but hi/lo are unchanged.
- Signed overflow (src_a = -2^(WIDTH-1), src_b = -1): lo = -2^(WIDTH-1), hi = 0.
- Latency is fixed by the parameters and independent of operand values. Internal method (iterative or pipelined) is free, provided results appear at the specified edge.

Test Plan:
- Reset, then mult with src_a=0xFFFFFFFE (-2), src_b=3 at WIDTH=32, MUL_CYCLES=5 -> busy high 5 cycles; done pulses on the 5th cycle; hi=0xFFFFFFFF, lo=0xFFFFFFFA. Same operands with multu -> hi=0x00000002, lo=0xFFFFFFFA.
- mthi 0, mtlo 10, then maddu 3*4 -> lo=22, hi=0. Then msub 5*5 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div src_a=-7, src_b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), after exactly 10 busy cycles. divu 7/0 -> full 10 busy cycles, done pulses, hi/lo unchanged.
- div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start mult 6*7, assert cancel in the 3rd busy cycle -> busy=0 next cycle, done never pulses, hi/lo keep their prior values. Repeat with reset instead of cancel -> hi=lo=0.
- Same-cycle start(madd 2*2) with lo_we, wdata=100 -> lo=104. Start and mtlo issued while busy -> ignored, result unaffected. New start in the done cycle -> accepted, busy stays high continuously.
